// File: rtl/cla_arith_pkg.sv
// Shared arithmetic-unit definitions for the lookahead adder/divider slice.
//   state_e       : divider FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   DIV_ZERO_QUOT : quotient reported for a zero divisor (all ones)
package cla_arith_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/cla_sub_17bit.sv
// Combinational lookahead subtractor: diff = a - b, computed as a + ~b + 1.
//   a, b  : W-bit unsigned operands (W = 17 in the divider)
//   diff  : W-bit difference
//   cout  : carry out of the MSB; 0 means the subtraction borrowed
// Carries are resolved in 3-bit lookahead groups; groups chain through their
// carry-in. The operand vectors are zero-padded to a whole number of groups,
// so the padding bits never generate or propagate.
module cla_sub_17bit #(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         cout
);

  localparam int unsigned NG = (W + 2) / 3;
  localparam int unsigned WP = NG * 3;

  logic [WP-1:0] p;
  logic [WP-1:0] g;
  logic [WP-1:0] x;
  logic [WP:0]   c;

  always_comb begin
    p        = '0;
    g        = '0;
    x        = '0;
    c        = '0;
    p[W-1:0] = a | ~b;
    g[W-1:0] = a & ~b;
    x[W-1:0] = a ^ ~b;
    c[0]     = 1'b1;
    for (int unsigned i = 0; i < NG; i++) begin
      c[3*i+1] = g[3*i] | (p[3*i] & c[3*i]);
      c[3*i+2] = g[3*i+1] | (p[3*i+1] & g[3*i]) | (p[3*i+1] & p[3*i] & c[3*i]);
      c[3*i+3] = g[3*i+2] | (p[3*i+2] & g[3*i+1]) | (p[3*i+2] & p[3*i+1] & g[3*i])
               | (p[3*i+2] & p[3*i+1] & p[3*i] & c[3*i]);
    end
    diff = x[W-1:0] ^ c[W-1:0];
    cout = c[W];
  end

endmodule

// File: rtl/cla_seq_divider_16bit.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : request, sampled only while ready=1
//   dividend     : numerator, captured on acceptance
//   divisor      : denominator, captured on acceptance
//   ready        : high in IDLE
//   done         : one-cycle pulse, results valid from this cycle
//   quotient     : registered quotient (all ones on divide-by-zero)
//   remainder    : registered remainder (dividend on divide-by-zero)
//   div_by_zero  : registered flag, set with done when divisor==0
module cla_seq_divider_16bit
  import cla_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remr_q, remr_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   sub_diff;
  logic             sub_cout;
  logic             borrow;
  logic [WIDTH:0]   rem_sel;
  logic             rem_msb_unused;

  cla_sub_17bit #(
    .W (WIDTH + 1)
  ) u_sub (
    .a    (s),
    .b    ({1'b0, dvs_q}),
    .diff (sub_diff),
    .cout (sub_cout)
  );

  // The 17-bit partial remainder is always below the divisor after a
  // restoring step, so its MSB is zero and only the low WIDTH bits are kept.
  always_comb begin
    s              = {rem_q, q_q[WIDTH-1]};
    borrow         = ~sub_cout;
    rem_sel        = borrow ? s : sub_diff;
    rem_msb_unused = rem_sel[WIDTH];
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remr_d  = remr_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dvs_d = divisor;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            state_d = S_DONE;
            quot_d  = DIV_ZERO_QUOT;
            remr_d  = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            rem_d   = '0;
            q_d     = dividend;
            cnt_d   = '0;
          end
        end
      end
      S_RUN: begin
        rem_d = rem_sel[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          quot_d  = q_d;
          remr_d  = rem_d;
          dbz_d   = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remr_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remr_q  <= remr_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    ready       = (state_q == S_IDLE);
    done        = (state_q == S_DONE);
    quotient    = quot_q;
    remainder   = remr_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_cla_seq_divider_16bit.sv
// Scoreboard bench for cla_seq_divider_16bit: the driver pushes the expected
// response for every accepted start, the monitor pops on every done pulse.
module tb_cla_seq_divider_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        ready;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  cla_seq_divider_16bit #(
    .WIDTH (16),
    .CNT_W (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;
  logic [15:0] hold_q = '0;
  logic [15:0] hold_r = '0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] eq, er;
    logic        ez;
    int unsigned lat;
    if (!rst_n) begin
      prev_done = 1'b0;
      hold_q    = '0;
      hold_r    = '0;
    end else begin
      if (done) begin
        check("ready_with_done", !ready, 32'(ready), 32'd0);
        check("done_width", !prev_done, 32'(prev_done), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 1'b0, 32'(quotient), 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.b == 0) begin
            eq = 16'hFFFF; er = e.a; ez = 1'b1; lat = 0;
          end else begin
            eq = e.a / e.b; er = e.a % e.b; ez = 1'b0; lat = 16;
          end
          check("quotient", quotient == eq, 32'(quotient), 32'(eq));
          check("remainder", remainder == er, 32'(remainder), 32'(er));
          check("div_by_zero", div_by_zero == ez, 32'(div_by_zero), 32'(ez));
          check("latency", (cyc - e.acc) == lat, cyc - e.acc, lat);
          if (e.b != 0)
            check("invariant",
                  (32'(e.a) == 32'(quotient) * 32'(e.b) + 32'(remainder)) && (remainder < e.b),
                  {quotient, remainder}, {eq, er});
        end
        hold_q = quotient;
        hold_r = remainder;
      end else begin
        check("hold", {quotient, remainder} == {hold_q, hold_r},
              {quotient, remainder}, {hold_q, hold_r});
      end
      prev_done = done;
    end
  end

  // Called at a negedge; waits for ready, issues one start, returns at the
  // next negedge with operands scrambled.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int unsigned n = 0;
    while (!ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 1'b0, 32'(ready), 32'd1);
      return;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back('{a: a, b: b, acc: cyc + 1});
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    check("ready_drops", !ready, 32'(ready), 32'd0);
  endtask

  initial begin
    int unsigned n;
    logic [15:0] ra, rb;

    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", ready == 1'b1, 32'(ready), 32'd1);
    check("rst_done", done == 1'b0, 32'(done), 32'd0);
    check("rst_outputs", {quotient, remainder, div_by_zero} == '0,
          {quotient, remainder}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'd100, 16'd7);
    issue(16'hFFFF, 16'd1);
    issue(16'h1234, 16'hFFFF);
    issue(16'hABCD, 16'd0);
    issue(16'd9, 16'd3);

    // Starts during RUN and during the done cycle must be ignored.
    issue(16'd50000, 16'd3);
    repeat (4) @(negedge clk);
    dividend = 16'd777; divisor = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", done, 32'(done), 32'd1);
    dividend = 16'd4321; divisor = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue(16'd60000, 16'd7);

    // Reset in the middle of an operation.
    issue(16'd1000, 16'd10);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", ready == 1'b1, 32'(ready), 32'd1);
    check("abort_done", done == 1'b0, 32'(done), 32'd0);
    check("abort_outputs", {quotient, remainder, div_by_zero} == '0,
          {quotient, remainder}, 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'd1000, 16'd10);

    for (int i = 0; i < 2000; i++) begin
      ra = ($urandom_range(7) == 0) ? 16'($urandom_range(255)) : 16'($urandom);
      case ($urandom_range(15))
        0:       rb = 16'd0;
        1, 2, 3: rb = 16'($urandom_range(255));
        4:       rb = 16'd1;
        default: rb = 16'($urandom);
      endcase
      issue(ra, rb);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size() == 0, 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
